feature_frame_buffer: RTL and testbench
=======================================

Name: feature_frame_buffer

Overview:
- Sits directly downstream of the centre/scale stage. Captures its stream of 32-bit SMC-float samples, one `srdyi_i` pulse per sample, into frames of NUM_FEAT words.
- Each completed frame is streamed to the classifier datapath one word per accepted handshake.
- Two banks (ping-pong), so capture continues while the previous frame drains.
- Data passes bit-exact; no arithmetic on sample values.

Parameters:
- NUM_FEAT, 8: samples per frame; must be ≥2.
- IDX_W, 3: index width; must equal ceil(log2(NUM_FEAT)).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- GlobalReset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- x_i  input  32  SMC-float sample from the centre/scale stage.
- srdyi_i  input  1  x_i valid this cycle; single-cycle pulse per sample, no backpressure upstream.
- y_o  output  32  frame word being presented.
- idx_o  output  IDX_W  position of y_o within its frame (0..NUM_FEAT-1).
- last_o  output  1  high when idx_o == NUM_FEAT-1 and srdyo_o high.
- srdyo_o  output  1  y_o/idx_o/last_o valid.
- drdyi_i  input  1  downstream accepts; a transfer occurs on a posedge where srdyo_o && drdyi_i.
- ovf_clr_i  input  1  clears ovf_o.
- ovf_o  output  1  sticky: a sample was dropped.

Behaviour:
- Storage: two banks of NUM_FEAT×32 registers; no reset required on contents.
- Control state: `full[1:0]`, `wr_bank`, `wr_idx`, `rd_bank`, `rd_idx`, `ovf`.
- Reset (GlobalReset low, asynchronous):
  - `full` = 0, `wr_bank` = `rd_bank` = 0, `wr_idx` = `rd_idx` = 0, `ovf` = 0.
  - Outputs: srdyo_o = 0, y_o = 0, idx_o = 0, last_o = 0, ovf_o = 0.
  - Reset mid-frame discards all partial and complete frames.
- Write side, on a posedge with srdyi_i = 1:
  - If `full[wr_bank]` = 0: store x_i at `[wr_bank][wr_idx]`.
  - If `wr_idx` == NUM_FEAT-1 at that edge: set `full[wr_bank]`, toggle `wr_bank`, set `wr_idx` = 0. Otherwise increment `wr_idx`.
  - If `full[wr_bank]` = 1: drop the sample, set `ovf`; `wr_idx` and `wr_bank` unchanged.
- Read side:
  - srdyo_o = `full[rd_bank]`.
  - When srdyo_o is high: y_o = `[rd_bank][rd_idx]`, idx_o = `rd_idx`. When srdyo_o is low: y_o = 0, idx_o = 0, last_o = 0.
  - All outputs derive from registers only; no combinational path from any input to any output.
- Read FSM:
  - IDLE (`full[rd_bank]` = 0) → STREAM when `full[rd_bank]` becomes 1.
  - In STREAM, each transfer increments `rd_idx`.
  - A transfer with `rd_idx` == NUM_FEAT-1 clears `full[rd_bank]`, toggles `rd_bank`, and sets `rd_idx` = 0. The FSM then goes to IDLE, or stays in STREAM if the other bank is already full.
  - drdyi_i low holds all outputs stable.
- Latency: the edge that accepts the last sample of a frame sets `full`. srdyo_o and word 0 are valid in the cycle after that edge. With drdyi_i tied high, a frame drains in NUM_FEAT cycles.
- Ordering: frames are delivered in capture order. `rd_bank` always trails `wr_bank`, so banks alternate 0,1,0,…
- Simultaneous events, all decided on pre-edge state:
  - A sample targeting a bank whose final word is transferred on the same edge is dropped; `ovf` is set.
  - Frame completion on the write side and frame release on the read side (different banks) on the same edge both take effect.
  - ovf_clr_i and a drop on the same edge: `ovf` ends at 1 (set wins).
- ovf_o = `ovf`. It is cleared only by ovf_clr_i (without a same-edge drop) or by reset.
- Back-to-back upstream pulses (srdyi_i high every cycle) are supported at full rate.

Test Plan:
- Reset, then 8 pulses with x_i = 0x3F800000 + k (k = 0..7), drdyi_i = 1 → srdyo_o rises the cycle after the 8th pulse. Then 8 consecutive transfers y_o = 0x3F800000..0x3F800007, idx_o 0..7, last_o only on idx 7, srdyo_o low after, ovf_o = 0.
- drdyi_i = 0 while 16 samples arrive (two frames) → srdyo_o high, y_o holds frame-0 word 0. The 17th sample is dropped and ovf_o rises. Releasing drdyi_i yields frame 0, then frame 1 back-to-back (16 transfers, no bubble), with correct values.
- Continuous pulses, drdyi_i = 1 → sustained streaming with no drops; ovf_o stays 0 over 10 frames; per-frame word k equals the k-th sample of that frame.
- drdyi_i toggling 1/0 each cycle during a drain → each word is presented until accepted; no duplicates or skips; idx_o sequence is 0..7.
- GlobalReset asserted asynchronously (between edges) after 5 samples and during a drain → outputs go to 0 immediately. After release, the next 8 samples form a fresh frame with idx 0..7.
- After a drop (ovf_o = 1): pulse ovf_clr_i → ovf_o = 0 next cycle. Pulse ovf_clr_i on the same edge as a drop → ovf_o stays 1.

Source files
------------

// File: rtl/feature_frame_buffer.sv
// feature_frame_buffer
//   Ping-pong frame buffer between the centre/scale stage and the classifier
//   datapath. Samples are grouped into frames of NUM_FEAT words. A frame is
//   captured into one bank while the previously completed frame drains from
//   the other bank. Sample values are passed through unchanged.
//
// Ports
//   clk          single clock; all state updates on posedge
//   GlobalReset  asynchronous active-low reset
//   x_i          32-bit sample from the centre/scale stage
//   srdyi_i      x_i valid this cycle (no upstream backpressure)
//   y_o          frame word being presented
//   idx_o        position of y_o within its frame
//   last_o       high on the final word of a frame
//   srdyo_o      y_o/idx_o/last_o valid
//   drdyi_i      downstream accepts; transfer when srdyo_o && drdyi_i
//   ovf_clr_i    clears ovf_o
//   ovf_o        sticky flag: a sample was dropped
module feature_frame_buffer #(
   parameter int unsigned NUM_FEAT = 8,
   parameter int unsigned IDX_W    = 3
) (
   input  logic             clk,
   input  logic             GlobalReset,
   input  logic [31:0]      x_i,
   input  logic             srdyi_i,
   output logic [31:0]      y_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             last_o,
   output logic             srdyo_o,
   input  logic             drdyi_i,
   input  logic             ovf_clr_i,
   output logic             ovf_o
);

   localparam int unsigned      DATA_W   = 32;
   localparam int unsigned      NUM_BANK = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } rd_state_t;

   // Frame storage; contents need no reset since reads are gated by full_q
   logic [DATA_W-1:0] mem [NUM_BANK][NUM_FEAT];

   rd_state_t          state_q, state_d;
   logic [1:0]         full_q, full_d;
   logic               wr_bank_q, wr_bank_d;
   logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
   logic               rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
   logic               ovf_q, ovf_d;

   logic               wr_en;
   logic               drop;

   logic [DATA_W-1:0]  y_d;
   logic [IDX_W-1:0]   idx_d;
   logic               last_d;
   logic               srdyo_d;

   // Sample capture into the active write bank
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank_q][wr_idx_q] <= x_i;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state_q   <= ST_IDLE;
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         ovf_q     <= 1'b0;
         y_o       <= '0;
         idx_o     <= '0;
         last_o    <= 1'b0;
         srdyo_o   <= 1'b0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_idx_q  <= wr_idx_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
         ovf_q     <= ovf_d;
         y_o       <= y_d;
         idx_o     <= idx_d;
         last_o    <= last_d;
         srdyo_o   <= srdyo_d;
      end
   end

   assign ovf_o = ovf_q;

   // Next-state for write side, read FSM, overflow flag and output registers
   always_comb begin
      state_d   = state_q;
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      rd_bank_d = rd_bank_q;
      rd_idx_d  = rd_idx_q;
      ovf_d     = ovf_q;
      y_d       = '0;
      idx_d     = '0;
      last_d    = 1'b0;
      srdyo_d   = 1'b0;

      // All decisions use pre-edge full_q, so a sample aimed at a bank whose
      // last word leaves on this same edge is still dropped.
      wr_en = srdyi_i && !full_q[wr_bank_q];
      drop  = srdyi_i &&  full_q[wr_bank_q];

      if (wr_en) begin
         if (wr_idx_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
         end
      end

      // Set beats clear when both happen on one edge
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end

      // Write completes into a non-full bank and release frees a full one,
      // so both updates to full_d always target different banks.
      case (state_q)
         ST_IDLE: begin
            if (full_d[rd_bank_q]) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (drdyi_i) begin
               if (rd_idx_q == LAST_IDX) begin
                  full_d[rd_bank_q] = 1'b0;
                  rd_bank_d         = ~rd_bank_q;
                  rd_idx_d          = '0;
                  state_d           = full_d[~rd_bank_q] ? ST_STREAM : ST_IDLE;
               end else begin
                  rd_idx_d = rd_idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs registered from next state. The word selected here was
      // always written on an earlier edge: a bank only becomes readable on
      // the edge that writes its final word, while reading starts at word 0.
      if (state_d == ST_STREAM) begin
         srdyo_d = 1'b1;
         idx_d   = rd_idx_d;
         last_d  = (rd_idx_d == LAST_IDX);
         y_d     = mem[rd_bank_d][rd_idx_d];
      end
   end

endmodule

// File: tb/tb_feature_frame_buffer.sv
// Directed self-checking bench for feature_frame_buffer.
module tb_feature_frame_buffer;

   localparam int unsigned NUM_FEAT = 8;
   localparam int unsigned IDX_W    = 3;

   logic             clk;
   logic             GlobalReset;
   logic [31:0]      x_i;
   logic             srdyi_i;
   logic [31:0]      y_o;
   logic [IDX_W-1:0] idx_o;
   logic             last_o;
   logic             srdyo_o;
   logic             drdyi_i;
   logic             ovf_clr_i;
   logic             ovf_o;

   int checks;
   int errors;
   int n;

   feature_frame_buffer #(
      .NUM_FEAT (NUM_FEAT),
      .IDX_W    (IDX_W)
   ) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .x_i         (x_i),
      .srdyi_i     (srdyi_i),
      .y_o         (y_o),
      .idx_o       (idx_o),
      .last_o      (last_o),
      .srdyo_o     (srdyo_o),
      .drdyi_i     (drdyi_i),
      .ovf_clr_i   (ovf_clr_i),
      .ovf_o       (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [31:0] v);
      srdyi_i = 1'b1;
      x_i     = v;
      tick();
      srdyi_i = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      GlobalReset = 1'b0;
      x_i         = '0;
      srdyi_i     = 1'b0;
      drdyi_i     = 1'b0;
      ovf_clr_i   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_srdyo", 32'(srdyo_o), 32'd0);
      chk("rst_y",     y_o,          32'd0);
      chk("rst_idx",   32'(idx_o),   32'd0);
      chk("rst_last",  32'(last_o),  32'd0);
      chk("rst_ovf",   32'(ovf_o),   32'd0);
      GlobalReset = 1'b1;
      tick();

      // Single frame, latency and drain
      drdyi_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         srdyi_i = 1'b1;
         x_i     = 32'h3F80_0000 + 32'(k);
         tick();
         if (k == 6) chk("t1_srdyo_early", 32'(srdyo_o), 32'd0);
      end
      srdyi_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("t1_srdyo", 32'(srdyo_o), 32'd1);
         chk("t1_y",     y_o,          32'h3F80_0000 + 32'(k));
         chk("t1_idx",   32'(idx_o),   32'(k));
         chk("t1_last",  32'(last_o),  32'(k == 7));
         tick();
      end
      chk("t1_srdyo_after", 32'(srdyo_o), 32'd0);
      chk("t1_ovf",         32'(ovf_o),   32'd0);

      // Two frames held, then overflow, then back-to-back drain
      drdyi_i = 1'b0;
      for (int k = 0; k < 16; k++) send(32'h0000_1000 + 32'(k));
      chk("t2_srdyo_hold", 32'(srdyo_o), 32'd1);
      chk("t2_y_hold",     y_o,          32'h0000_1000);
      chk("t2_idx_hold",   32'(idx_o),   32'd0);
      chk("t2_ovf_pre",    32'(ovf_o),   32'd0);
      send(32'h0000_1FFF);
      chk("t2_ovf_drop",   32'(ovf_o),   32'd1);
      chk("t2_y_drop",     y_o,          32'h0000_1000);
      drdyi_i = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk("t2_srdyo", 32'(srdyo_o), 32'd1);
         chk("t2_y",     y_o,          32'h0000_1000 + 32'(k));
         chk("t2_idx",   32'(idx_o),   32'(k % 8));
         tick();
      end
      chk("t2_srdyo_after", 32'(srdyo_o), 32'd0);
      drdyi_i   = 1'b0;
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("t2_ovf_clr", 32'(ovf_o), 32'd0);

      // Continuous full-rate capture and drain over 10 frames
      drdyi_i = 1'b1;
      n       = 0;
      for (int c = 0; c < 96; c++) begin
         srdyi_i = (c < 80);
         x_i     = 32'h0000_2000 + 32'(c);
         tick();
         if (srdyo_o) begin
            chk("t3_y",   y_o,        32'h0000_2000 + 32'(n));
            chk("t3_idx", 32'(idx_o), 32'(n % 8));
            n++;
         end
      end
      srdyi_i = 1'b0;
      chk("t3_count", 32'(n),     32'd80);
      chk("t3_ovf",   32'(ovf_o), 32'd0);

      // Drain with drdyi toggling
      drdyi_i = 1'b0;
      for (int k = 0; k < 8; k++) send(32'h0000_3000 + 32'(k));
      n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         chk("t4_srdyo", 32'(srdyo_o), 32'd1);
         chk("t4_y",     y_o,          32'h0000_3000 + 32'(n));
         chk("t4_idx",   32'(idx_o),   32'(n));
         drdyi_i = (c % 2 == 0);
         if (drdyi_i) n++;
         tick();
      end
      drdyi_i = 1'b0;
      chk("t4_count",       32'(n),       32'd8);
      chk("t4_srdyo_after", 32'(srdyo_o), 32'd0);

      // Asynchronous reset during a drain with a partial frame pending
      for (int k = 0; k < 8; k++) send(32'h0000_4000 + 32'(k));
      for (int k = 0; k < 5; k++) send(32'h0000_4100 + 32'(k));
      drdyi_i = 1'b1;
      tick();
      tick();
      chk("t5_srdyo_pre", 32'(srdyo_o), 32'd1);
      chk("t5_y_pre",     y_o,          32'h0000_4002);
      #2;
      GlobalReset = 1'b0;
      #1;
      chk("t5_rst_srdyo", 32'(srdyo_o), 32'd0);
      chk("t5_rst_y",     y_o,          32'd0);
      chk("t5_rst_idx",   32'(idx_o),   32'd0);
      chk("t5_rst_last",  32'(last_o),  32'd0);
      #2;
      GlobalReset = 1'b1;
      drdyi_i     = 1'b0;
      for (int k = 0; k < 8; k++) begin
         srdyi_i = 1'b1;
         x_i     = 32'h0000_5000 + 32'(k);
         tick();
         if (k == 6) chk("t5_srdyo_early", 32'(srdyo_o), 32'd0);
      end
      srdyi_i = 1'b0;
      chk("t5_srdyo", 32'(srdyo_o), 32'd1);
      drdyi_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("t5_y",   y_o,        32'h0000_5000 + 32'(k));
         chk("t5_idx", 32'(idx_o), 32'(k));
         tick();
      end
      chk("t5_srdyo_after", 32'(srdyo_o), 32'd0);

      // Clear and drop on the same edge, then drop on a releasing bank
      drdyi_i = 1'b0;
      for (int k = 0; k < 16; k++) send(32'h0000_6000 + 32'(k));
      srdyi_i   = 1'b1;
      x_i       = 32'hDEAD_0000;
      ovf_clr_i = 1'b1;
      tick();
      srdyi_i   = 1'b0;
      ovf_clr_i = 1'b0;
      chk("t6_ovf_setwins", 32'(ovf_o), 32'd1);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("t6_ovf_clr", 32'(ovf_o), 32'd0);
      drdyi_i = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk("t6_yA", y_o, 32'h0000_6000 + 32'(k));
         tick();
      end
      chk("t6_lastA", 32'(last_o), 32'd1);
      send(32'h0000_0BAD);
      chk("t6_ovf_rel",  32'(ovf_o), 32'd1);
      for (int k = 0; k < 8; k++) begin
         chk("t6_yB", y_o, 32'h0000_6008 + 32'(k));
         tick();
      end
      chk("t6_srdyo_after", 32'(srdyo_o), 32'd0);
      for (int k = 0; k < 8; k++) begin
         send(32'h0000_7000 + 32'(k));
         if (k == 6) chk("t6_srdyo_early", 32'(srdyo_o), 32'd0);
      end
      chk("t6_srdyo_new", 32'(srdyo_o), 32'd1);
      chk("t6_y_new",     y_o,          32'h0000_7000);
      for (int k = 0; k < 8; k++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
